pwm_fade_sequencer: RTL and testbench
=====================================

PWM_FADE_SEQUENCER -- requirements
Module: pwm_fade_sequencer

Interface
REQ-001 SHALL have parameter R, default 8: duty resolution in bits.
REQ-002 SHALL have parameter TIMER_BITS, default 24: step-interval counter width.
REQ-003 SHALL have port clk, input, 1: rising-edge clock.
REQ-004 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: single-cycle request to begin a fade run.
REQ-006 SHALL have port stop, input, 1: abort request.
REQ-007 SHALL have port step_interval, input, TIMER_BITS: clocks per step minus one.
REQ-008 SHALL have port duty_max, input, R: peak duty level.
REQ-009 SHALL have port hold_steps, input, R: steps held at peak and at zero.
REQ-010 SHALL have port num_cycles, input, 8: number of up/down cycles; 0 means run until stopped.
REQ-011 SHALL have port duty, output, R+1: duty value driving the PWM generator, zero-extended.
REQ-012 SHALL have port busy, output, 1: high while a run is active.
REQ-013 SHALL have port done, output, 1: one-clock pulse on normal completion.

Function
REQ-014 SHALL implement an FSM with states IDLE, RAMP_UP, HOLD_HIGH, RAMP_DOWN and HOLD_LOW.
REQ-015 SHALL, in IDLE with start=1 and stop=0, latch step_interval, duty_max, hold_steps and num_cycles; clear duty, the step timer, the hold count and the cycle count; enter RAMP_UP on the next edge.
REQ-016 SHALL ignore start while busy=1; latched configuration SHALL NOT change mid-run.
REQ-017 SHALL generate an internal step tick when the step timer equals the latched step_interval, then clear the timer (tick period = step_interval+1 clocks; step_interval=0 gives a tick every clock); the timer SHALL run only while busy.
REQ-018 SHALL, in RAMP_UP on a tick, increment duty if duty < duty_max, and go to HOLD_HIGH on the tick where duty reaches duty_max (duty_max=0 gives HOLD_HIGH on the first tick with duty unchanged).
REQ-019 SHALL, in HOLD_HIGH and HOLD_LOW, count ticks and exit on the tick that makes the count equal hold_steps; hold_steps=0 SHALL exit on the next clock without waiting for a tick; the count SHALL clear on every hold entry.
REQ-020 SHALL, in RAMP_DOWN on a tick, decrement duty, and go to HOLD_LOW on the tick where duty reaches 0.
REQ-021 SHALL exit HOLD_LOW as follows: increment the cycle count; if num_cycles≠0 and the new count equals num_cycles, go to IDLE with done=1 for exactly one clock; otherwise go to RAMP_UP.
REQ-022 SHALL, when stop=1 in any state, go to IDLE on the next edge with duty=0, busy=0 and done=0; stop SHALL win over a simultaneous start or tick.
REQ-023 SHALL drive busy=1 in every state except IDLE; duty, busy and done SHALL be registered outputs.
REQ-024 SHALL never make duty exceed duty_max or wrap below 0.
REQ-025 SHALL wrap the cycle count modulo 256 when num_cycles=0, without asserting done.

Reset
REQ-026 SHALL, while reset_n=0, asynchronously force state IDLE, duty=0, busy=0, done=0, and clear all counters and latched configuration.
REQ-027 SHALL, on reset mid-run, abandon the run; no done pulse SHALL follow reset release.

Structure
REQ-028 SHALL take the state encodings (IDLE=0, RAMP_UP=1, HOLD_HIGH=2, RAMP_DOWN=3, HOLD_LOW=4) from the shared pwm_pkg package/include.
REQ-029 SHALL implement the step timer as one sub-module instance, step_timer (enable, FINAL_VALUE, done tick), parameterised by TIMER_BITS.
REQ-030 SHALL connect duty port-compatibly to the duty input of the team's PWM generator.

Verification
REQ-031 SHALL cover: step_interval=0, duty_max=3, hold_steps=1, num_cycles=1, start pulse -> duty 0,1,2,3,3,2,1,0,0 on consecutive clocks, then done for one clock and busy=0.
REQ-032 SHALL cover: step_interval=4, duty_max=2 -> duty changes exactly every 5 clocks.
REQ-033 SHALL cover: num_cycles=0, stop asserted mid-RAMP_DOWN -> IDLE next clock, duty=0, no done pulse.
REQ-034 SHALL cover: duty_max=0, hold_steps=0, num_cycles=2 -> duty stays 0 throughout, exactly one done pulse, busy falls with it.
REQ-035 SHALL cover: start and stop in the same clock in IDLE -> remains IDLE; start while busy -> latched config unchanged.
REQ-036 SHALL cover: reset_n pulsed low mid-HOLD_HIGH -> outputs 0 immediately (asynchronously), no done pulse after release.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM fade sequencer slice.
// Holds the fade FSM state encoding and the cycle-counter width.
package pwm_pkg;

    localparam int CYCLE_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RAMP_UP   = 3'd1,
        ST_HOLD_HIGH = 3'd2,
        ST_RAMP_DOWN = 3'd3,
        ST_HOLD_LOW  = 3'd4
    } fade_state_e;

endpackage

// File: rtl/pwm_fade_sequencer_step_timer.sv
// Step timer: counts clocks while enabled and emits a one-clock tick
// when the count equals final_value_i. Ports: clk, reset_n, enable_i,
// clear_i, final_value_i (clocks per tick minus one), tick_o.
module step_timer #(
    parameter int TIMER_BITS = 24
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable_i,
    input  logic                  clear_i,
    input  logic [TIMER_BITS-1:0] final_value_i,
    output logic                  tick_o
);

    logic [TIMER_BITS-1:0] cnt_q;
    logic [TIMER_BITS-1:0] cnt_d;

    assign tick_o = enable_i && (cnt_q == final_value_i);

    // Held at zero while disabled so every run starts from a clean phase.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear_i || !enable_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pwm_fade_sequencer.sv
// Fade sequencer: ramps a PWM duty up to a peak, holds, ramps down,
// holds at zero, for a configured number of cycles (0 = until stop).
// Ports: clk, reset_n, start, stop, step_interval, duty_max,
// hold_steps, num_cycles in; duty (zero-extended), busy, done out.
module pwm_fade_sequencer
    import pwm_pkg::*;
#(
    parameter int R          = 8,
    parameter int TIMER_BITS = 24
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic [TIMER_BITS-1:0] step_interval,
    input  logic [R-1:0]          duty_max,
    input  logic [R-1:0]          hold_steps,
    input  logic [CYCLE_BITS-1:0] num_cycles,
    output logic [R:0]            duty,
    output logic                  busy,
    output logic                  done
);

    fade_state_e state_q, state_d;

    logic [R-1:0]          duty_q, duty_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [R-1:0]          hcnt_q, hcnt_d;
    logic [CYCLE_BITS-1:0] cyc_q, cyc_d;

    logic [TIMER_BITS-1:0] ivl_q, ivl_d;
    logic [R-1:0]          dmax_q, dmax_d;
    logic [R-1:0]          hstep_q, hstep_d;
    logic [CYCLE_BITS-1:0] ncyc_q, ncyc_d;

    logic                  tick;
    logic                  launch;
    logic [R-1:0]          duty_up;
    logic [R-1:0]          duty_dn;
    logic [R-1:0]          hcnt_inc;
    logic                  hold_exit;
    logic [CYCLE_BITS-1:0] cyc_inc;
    logic                  run_end;

    step_timer #(
        .TIMER_BITS(TIMER_BITS)
    ) u_step_timer (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable_i     (busy_q),
        .clear_i      (launch),
        .final_value_i(ivl_q),
        .tick_o       (tick)
    );

    assign launch  = (state_q == ST_IDLE) && start && !stop;
    // Saturating steps keep duty inside [0, duty_max].
    assign duty_up = (duty_q < dmax_q) ? duty_q + 1'b1 : duty_q;
    assign duty_dn = (duty_q != '0) ? duty_q - 1'b1 : duty_q;
    assign hcnt_inc = hcnt_q + 1'b1;
    // A zero hold length leaves on the very next clock, tick or not.
    assign hold_exit = (hstep_q == '0) || (tick && hcnt_inc == hstep_q);
    assign cyc_inc = cyc_q + 1'b1;
    assign run_end = (ncyc_q != '0) && (cyc_inc == ncyc_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            duty_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hcnt_q  <= '0;
            cyc_q   <= '0;
            ivl_q   <= '0;
            dmax_q  <= '0;
            hstep_q <= '0;
            ncyc_q  <= '0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hcnt_q  <= hcnt_d;
            cyc_q   <= cyc_d;
            ivl_q   <= ivl_d;
            dmax_q  <= dmax_d;
            hstep_q <= hstep_d;
            ncyc_q  <= ncyc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (stop) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) state_d = ST_RAMP_UP;
                end
                ST_RAMP_UP: begin
                    if (tick && duty_up == dmax_q) state_d = ST_HOLD_HIGH;
                end
                ST_HOLD_HIGH: begin
                    if (hold_exit) state_d = ST_RAMP_DOWN;
                end
                ST_RAMP_DOWN: begin
                    if (tick && duty_dn == '0) state_d = ST_HOLD_LOW;
                end
                ST_HOLD_LOW: begin
                    if (hold_exit) state_d = run_end ? ST_IDLE : ST_RAMP_UP;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        duty_d  = duty_q;
        hcnt_d  = hcnt_q;
        cyc_d   = cyc_q;
        ivl_d   = ivl_q;
        dmax_d  = dmax_q;
        hstep_d = hstep_q;
        ncyc_d  = ncyc_q;
        busy_d  = (state_d != ST_IDLE);
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (launch) begin
                    ivl_d   = step_interval;
                    dmax_d  = duty_max;
                    hstep_d = hold_steps;
                    ncyc_d  = num_cycles;
                    duty_d  = '0;
                    hcnt_d  = '0;
                    cyc_d   = '0;
                end
            end
            ST_RAMP_UP: begin
                if (tick) duty_d = duty_up;
            end
            ST_HOLD_HIGH: begin
                if (tick) hcnt_d = hcnt_inc;
            end
            ST_RAMP_DOWN: begin
                if (tick) duty_d = duty_dn;
            end
            ST_HOLD_LOW: begin
                if (tick) hcnt_d = hcnt_inc;
                if (hold_exit) begin
                    cyc_d  = cyc_inc;
                    done_d = run_end;
                end
            end
            default: begin
                duty_d = '0;
            end
        endcase
        // Hold count restarts on every state change, so each hold starts at 0.
        if (state_d != state_q) begin
            hcnt_d = '0;
        end
        if (stop) begin
            duty_d = '0;
            done_d = 1'b0;
        end
    end

    assign duty = {1'b0, duty_q};
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Scoreboard bench for pwm_fade_sequencer: a schedule-based model
// predicts per-clock duty/busy/done, a monitor compares every clock.
module tb_pwm_fade_sequencer;

    localparam int R  = 8;
    localparam int TB = 24;

    typedef struct packed {
        logic [R:0] duty;
        logic       busy;
        logic       done;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [TB-1:0] step_interval = '0;
    logic [R-1:0]  duty_max = '0;
    logic [R-1:0]  hold_steps = '0;
    logic [7:0]    num_cycles = '0;
    logic [R:0]    duty;
    logic          busy;
    logic          done;

    int    n_pass = 0;
    int    n_total = 0;
    string scen = "reset";
    exp_t  exp_q[$];
    exp_t  trace[$];
    int    m_d;
    int    m_p;

    pwm_fade_sequencer #(
        .R(R),
        .TIMER_BITS(TB)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .stop         (stop),
        .step_interval(step_interval),
        .duty_max     (duty_max),
        .hold_steps   (hold_steps),
        .num_cycles   (num_cycles),
        .duty         (duty),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input int d, input logic b, input logic dn);
        exp_t r;
        r.duty = 9'(d);
        r.busy = b;
        r.done = dn;
        return r;
    endfunction

    task automatic check(input string nm, input exp_t e);
        n_total++;
        if (duty === e.duty && busy === e.busy && done === e.done) begin
            n_pass++;
        end else begin
            $display("FAIL %s @%0t: got duty=%0d busy=%0b done=%0b, want duty=%0d busy=%0b done=%0b",
                     nm, $time, duty, busy, done, e.duty, e.busy, e.done);
        end
    endtask

    // One model action: either waits for the next step tick (ticks land on
    // clocks that are multiples of the period after start) or takes 1 clock.
    task automatic m_step(input bit on_tick, input int nd);
        int t;
        int tn;
        t  = trace.size() - 1;
        tn = on_tick ? ((t / m_p) + 1) * m_p : t + 1;
        while (trace.size() < tn) trace.push_back(mk(m_d, 1'b1, 1'b0));
        m_d = nd;
        trace.push_back(mk(m_d, 1'b1, 1'b0));
    endtask

    task automatic m_hold(input int hs);
        if (hs == 0) begin
            m_step(1'b0, m_d);
        end else begin
            for (int k = 0; k < hs; k++) m_step(1'b1, m_d);
        end
    endtask

    // trace[t] = outputs right after the t-th rising edge, edge 0 = start.
    task automatic build_trace(input int iv, input int mx, input int hs,
                               input int nc, input int maxlen);
        int cyc;
        int n;
        cyc = 0;
        m_p = iv + 1;
        m_d = 0;
        trace.delete();
        trace.push_back(mk(0, 1'b1, 1'b0));
        n = (mx == 0) ? 1 : mx;
        while (trace.size() <= maxlen) begin
            for (int k = 1; k <= n; k++) m_step(1'b1, (mx == 0) ? 0 : k);
            m_hold(hs);
            for (int k = 1; k <= n; k++) m_step(1'b1, (mx == 0) ? 0 : mx - k);
            m_hold(hs);
            cyc = (cyc + 1) % 256;
            if (nc != 0 && cyc == nc) begin
                trace[trace.size() - 1] = mk(0, 1'b0, 1'b1);
                trace.push_back(mk(0, 1'b0, 1'b0));
                return;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            start   = 1'b0;
            stop    = 1'b0;
            reset_n = 1'b1;
            exp_q.push_back(mk(0, 1'b0, 1'b0));
        end
    endtask

    // kind: 0 = run to completion, 1 = stop at abort_at, 2 = reset at abort_at
    task automatic run_fade(input string nm, input int iv, input int mx,
                            input int hs, input int nc, input int abort_at,
                            input int kind, input bit noisy);
        int last;
        scen = nm;
        build_trace(iv, mx, hs, nc, (kind != 0) ? abort_at : 4000);
        last = (kind != 0) ? abort_at : trace.size();
        for (int i = 0; i < last; i++) begin
            @(negedge clk);
            stop = 1'b0;
            if (i == 0) begin
                step_interval = TB'(iv);
                duty_max      = R'(mx);
                hold_steps    = R'(hs);
                num_cycles    = 8'(nc);
                start         = 1'b1;
            end else begin
                start = noisy && trace[i-1].busy && ($urandom_range(0, 3) == 0);
                if (noisy && trace[i-1].busy) begin
                    step_interval = TB'($urandom_range(0, 7));
                    duty_max      = R'($urandom_range(0, 255));
                    hold_steps    = R'($urandom_range(0, 9));
                    num_cycles    = 8'($urandom_range(0, 255));
                end
            end
            exp_q.push_back(trace[i]);
        end
        if (kind == 1) begin
            @(negedge clk);
            stop  = 1'b1;
            start = noisy;
            exp_q.push_back(mk(0, 1'b0, 1'b0));
        end else if (kind == 2) begin
            @(negedge clk);
            start   = 1'b0;
            reset_n = 1'b0;
            #1;
            check("async_reset", mk(0, 1'b0, 1'b0));
            exp_q.push_back(mk(0, 1'b0, 1'b0));
        end
        idle(5);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check(scen, e);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin : stim
        #12;
        check("reset_state", mk(0, 1'b0, 1'b0));
        idle(3);

        run_fade("basic_031", 0, 3, 1, 1, 0, 0, 1'b0);
        run_fade("interval_032", 4, 2, 1, 1, 0, 0, 1'b0);
        run_fade("stop_rampdown_033", 1, 4, 2, 0, 15, 1, 1'b0);
        run_fade("zero_peak_034", 0, 0, 0, 2, 0, 0, 1'b0);
        run_fade("start_busy_035", 2, 5, 2, 1, 0, 0, 1'b1);

        scen = "start_stop_idle";
        @(negedge clk);
        start = 1'b1;
        stop  = 1'b1;
        exp_q.push_back(mk(0, 1'b0, 1'b0));
        idle(3);

        run_fade("reset_hold_036", 2, 3, 4, 1, 14, 2, 1'b0);
        run_fade("wrap_cycles", 0, 0, 0, 0, 1100, 1, 1'b1);

        for (int k = 0; k < 6; k++) begin
            run_fade("rand_run", int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
                     int'($urandom_range(1, 3)), 0, 0, 1'b1);
        end
        for (int k = 0; k < 4; k++) begin
            run_fade("rand_stop", int'($urandom_range(0, 2)),
                     int'($urandom_range(1, 6)), int'($urandom_range(0, 2)),
                     0, int'($urandom_range(3, 80)), 1, 1'b1);
        end

        repeat (3) @(posedge clk);
        #2;
        n_total++;
        if (exp_q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
